// File: rtl/alu_divider_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_divider_if
//  Description : Request/result bundle for the 8-bit by 4-bit divider.
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_divider_if;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       busy;
    logic       done;
    logic       div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero
    );
endinterface
`default_nettype wire

// File: rtl/alu_divider.sv
`default_nettype none
// ============================================================================
//  Module      : alu_divider
//  Description : Unsigned 8/4 restoring divider, one quotient bit per cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_divider (
    input  wire logic     clock,
    input  wire logic     reset,
    alu_divider_if.slave  bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] c_steps = 4'd8;

    logic [1:0] r_state;
    logic [7:0] r_shift;   // dividend bits shift out MSB-first, quotient bits shift in
    logic [3:0] r_dvs;
    logic [4:0] r_prem;
    logic [3:0] r_cnt;
    logic [7:0] r_quotient;
    logic [3:0] r_remainder;
    logic       r_busy;
    logic       r_done;
    logic       r_dbz;

    logic [4:0] w_trial;
    logic [4:0] w_diff;
    logic       w_ge;
    logic [4:0] w_next_prem;
    logic [7:0] w_next_shift;
    logic       w_unused_prem_msb;

    // Partial remainder stays below the divisor, so its MSB is always zero before the shift.
    assign w_unused_prem_msb = r_prem[4];
    assign w_trial      = {r_prem[3:0], r_shift[7]};
    assign w_diff       = w_trial - {1'b0, r_dvs};
    assign w_ge         = (w_trial >= {1'b0, r_dvs});
    assign w_next_prem  = w_ge ? w_diff : w_trial;
    assign w_next_shift = {r_shift[6:0], w_ge};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_shift     <= 8'd0;
            r_dvs       <= 4'd0;
            r_prem      <= 5'd0;
            r_cnt       <= 4'd0;
            r_quotient  <= 8'd0;
            r_remainder <= 4'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.divisor == 4'd0) begin
                            r_quotient  <= 8'hFF;
                            r_remainder <= bus.dividend[3:0];
                            r_dbz       <= 1'b1;
                            r_done      <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_shift <= bus.dividend;
                            r_dvs   <= bus.divisor;
                            r_prem  <= 5'd0;
                            r_cnt   <= c_steps;
                            r_busy  <= 1'b1;
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_shift <= w_next_shift;
                    r_prem  <= w_next_prem;
                    r_cnt   <= r_cnt - 4'd1;
                    // Last step: publish the freshly completed quotient and remainder.
                    if (r_cnt == 4'd1) begin
                        r_quotient  <= w_next_shift;
                        r_remainder <= w_next_prem[3:0];
                        r_dbz       <= 1'b0;
                        r_done      <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_alu_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_divider
//  Description : Scoreboard bench for alu_divider against an arithmetic model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_divider;

    typedef struct {
        logic [7:0] q;
        logic [3:0] r;
        logic       dbz;
        int         due;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    logic [7:0] last_q = 8'd0;
    logic [3:0] last_r = 4'd0;
    logic       last_dbz = 1'b0;

    alu_divider_if bus ();

    alu_divider dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on each done pulse and polices busy and output hold.
    always @(negedge clock) begin
        exp_t e;
        logic exp_busy;
        exp_busy = (sb.size() > 0) && !sb[0].dbz && (cyc < sb[0].due);
        check("busy", int'(bus.busy), int'(exp_busy));
        if (bus.done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("done_cycle", cyc, e.due);
                check("quotient", int'(bus.quotient), int'(e.q));
                check("remainder", int'(bus.remainder), int'(e.r));
                check("div_by_zero", int'(bus.div_by_zero), int'(e.dbz));
                last_q   = e.q;
                last_r   = e.r;
                last_dbz = e.dbz;
            end
        end else begin
            if (sb.size() > 0 && sb[0].due <= cyc) begin
                check("missing_done", 0, 1);
                void'(sb.pop_front());
            end
            check("hold_quotient", int'(bus.quotient), int'(last_q));
            check("hold_remainder", int'(bus.remainder), int'(last_r));
            check("hold_dbz", int'(bus.div_by_zero), int'(last_dbz));
        end
    end

    // Drive one request at the next edge and record what the model says it must return.
    task automatic issue(input logic [7:0] a, input logic [3:0] b, input bit hold);
        exp_t e;
        @(negedge clock);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clock);
        #1;
        if (b == 4'd0) begin
            e.q   = 8'hFF;
            e.r   = 4'(a % 16);
            e.dbz = 1'b1;
            e.due = cyc;
        end else begin
            e.q   = 8'(int'(a) / int'(b));
            e.r   = 4'(int'(a) % int'(b));
            e.dbz = 1'b0;
            e.due = cyc + 8;
        end
        sb.push_back(e);
        if (!hold) bus.start = 1'b0;
    endtask

    // Wait out the rest of the operation, optionally poking start/operands (must be ignored).
    task automatic wait_op(input logic [3:0] b, input bit noise, input bit hold);
        int reps;
        reps = (b == 4'd0) ? 1 : 9;
        for (int i = 0; i < reps; i++) begin
            @(negedge clock);
            if (noise && ($urandom % 3 == 0)) begin
                bus.start    = 1'b1;
                bus.dividend = 8'($urandom);
                bus.divisor  = 4'($urandom);
            end else if (!hold) begin
                bus.start = 1'b0;
            end
            @(posedge clock);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            bus.start = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] a;
        logic [3:0] b;
        bus.start    = 1'b0;
        bus.dividend = 8'd0;
        bus.divisor  = 4'd0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_quotient", int'(bus.quotient), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_busy", int'(bus.busy), 0);
        @(posedge clock);
        #2 reset = 1'b0;

        issue(8'd200, 4'd7, 1'b0); wait_op(4'd7, 1'b0, 1'b0); idle(2);
        issue(8'd255, 4'd1, 1'b0); wait_op(4'd1, 1'b0, 1'b0); idle(3);
        issue(8'd5,   4'd9, 1'b0); wait_op(4'd9, 1'b0, 1'b0); idle(2);
        issue(8'hA7,  4'd0, 1'b0); wait_op(4'd0, 1'b0, 1'b0); idle(2);

        // Second start at E4 must be ignored.
        issue(8'd100, 4'd3, 1'b0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        bus.start = 1'b1; bus.dividend = 8'd50; bus.divisor = 4'd5;
        @(posedge clock);
        #1 bus.start = 1'b0;
        repeat (5) @(posedge clock);
        idle(2);

        // Asynchronous reset mid-run wipes the operation and all results.
        issue(8'd200, 4'd7, 1'b0);
        repeat (5) @(posedge clock);
        #2 reset = 1'b1;
        sb.delete();
        last_q = 8'd0; last_r = 4'd0; last_dbz = 1'b0;
        #1;
        check("arst_quotient", int'(bus.quotient), 0);
        check("arst_remainder", int'(bus.remainder), 0);
        check("arst_busy", int'(bus.busy), 0);
        check("arst_done", int'(bus.done), 0);
        check("arst_dbz", int'(bus.div_by_zero), 0);
        @(posedge clock);
        #2 reset = 1'b0;
        issue(8'd15, 4'd4, 1'b0); wait_op(4'd4, 1'b0, 1'b0); idle(2);

        // Exhaustive sweep with start held high: results must arrive every 10 cycles.
        for (int x = 0; x < 256; x++) begin
            for (int y = 1; y < 16; y++) begin
                issue(8'(x), 4'(y), 1'b1);
                wait_op(4'(y), 1'b0, 1'b1);
            end
        end
        idle(3);

        // Randomized traffic, zero divisors included, with ignored mid-run requests.
        for (int k = 0; k < 300; k++) begin
            a = 8'($urandom);
            b = 4'($urandom);
            issue(a, b, 1'b0);
            wait_op(b, 1'b1, 1'b0);
            if ($urandom % 2 == 0) idle(1 + int'($urandom % 3));
        end
        idle(2);

        repeat (20) @(posedge clock);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
